// File: rtl/alu_cmd_sequencer_pkg.sv
// alu_cmd_sequencer_pkg: state encoding, default error byte and byte-count helper
package alu_cmd_sequencer_pkg;
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_ISSUE = 3'd1;
   localparam logic [2:0] ST_WAIT = 3'd2;
   localparam logic [2:0] ST_SEND = 3'd3;
   localparam logic [2:0] ST_ERRS = 3'd4;
   typedef enum logic [2:0] {
      IDLE = ST_IDLE,
      ISSUE = ST_ISSUE,
      WAIT = ST_WAIT,
      SEND = ST_SEND,
      ERRS = ST_ERRS
   } state_t;
   localparam logic [7:0] ERR_CODE_DEF = 8'hEE;
   function automatic int nbytes(input int w);
      return (w + 7) / 8;
   endfunction
endpackage

// File: rtl/alu_cmd_sequencer_result_byte_serializer.sv
// alu_cmd_sequencer_result_byte_serializer: holds a captured result and streams it LSB byte first
module alu_cmd_sequencer_result_byte_serializer
   import alu_cmd_sequencer_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] result,
   input  logic         ready,
   output logic         valid,
   output logic [7:0]   data,
   output logic         last
);
   localparam int NB = nbytes(W);
   localparam int IW = NB > 1 ? $clog2(NB) : 1;
   localparam int PW = 8 * NB;
   logic [PW-1:0] res_q;
   logic [IW-1:0] idx_q;
   logic          busy_q;
   assign valid = busy_q;
   assign last = busy_q & ready & (idx_q == IW'(NB - 1));
   // zero-extended register keeps bits beyond W at 0 in the last byte
   assign data = 8'(res_q >> {idx_q, 3'b000});
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         res_q <= '0;
         idx_q <= '0;
         busy_q <= 1'b0;
      end else if (load) begin
         res_q <= PW'(result);
         idx_q <= '0;
         busy_q <= 1'b1;
      end else if (busy_q & ready) begin
         idx_q <= idx_q + 1'b1;
         busy_q <= ~last;
      end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: issues one command to the ALU, waits for its flag and streams the result bytes
module alu_cmd_sequencer
   import alu_cmd_sequencer_pkg::*;
#(
   parameter int         IN_DATA_WIDTH = 16,
   parameter int         OUT_DATA_WIDTH = 16,
   parameter int         FUNC_WIDTH = 4,
   parameter int         TIMEOUT = 15,
   parameter logic [7:0] ERR_CODE = ERR_CODE_DEF
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      CMD_VALID,
   output logic                      CMD_READY,
   input  logic [FUNC_WIDTH-1:0]     CMD_FUNC,
   input  logic [IN_DATA_WIDTH-1:0]  CMD_A,
   input  logic [IN_DATA_WIDTH-1:0]  CMD_B,
   output logic [IN_DATA_WIDTH-1:0]  ALU_A,
   output logic [IN_DATA_WIDTH-1:0]  ALU_B,
   output logic [FUNC_WIDTH-1:0]     ALU_FUNC,
   output logic                      ALU_EN,
   input  logic [OUT_DATA_WIDTH-1:0] ALU_OUT,
   input  logic                      ALU_OUT_VALID,
   output logic [7:0]                TX_DATA,
   output logic                      TX_VALID,
   input  logic                      TX_READY,
   output logic                      DONE,
   output logic                      ERR
);
   localparam int CW = $clog2(TIMEOUT + 1);
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic          rdy_q, done_q, err_q, accept, timeout;
   logic          ser_valid, ser_last;
   logic [7:0]    ser_data;
   assign accept = CMD_VALID & rdy_q;
   assign timeout = cnt_q == CW'(TIMEOUT - 1);
   always_ff @(posedge CLK or negedge RST)
      if (!RST) state_q <= IDLE;
      else state_q <= state_d;
   // a flag seen in ISSUE is stale, so only WAIT looks at ALU_OUT_VALID
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = accept ? ISSUE : IDLE;
         ISSUE:   state_d = WAIT;
         WAIT:    state_d = ALU_OUT_VALID ? SEND : timeout ? ERRS : WAIT;
         SEND:    state_d = ser_last ? IDLE : SEND;
         ERRS:    state_d = TX_READY ? IDLE : ERRS;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         cnt_q <= '0;
         rdy_q <= 1'b0;
         done_q <= 1'b0;
         err_q <= 1'b0;
         ALU_A <= '0;
         ALU_B <= '0;
         ALU_FUNC <= '0;
      end else begin
         cnt_q <= state_q != WAIT ? '0 : &cnt_q ? cnt_q : cnt_q + 1'b1;
         rdy_q <= state_d == IDLE;
         done_q <= state_q == SEND && ser_last;
         err_q <= state_q == ERRS && TX_READY;
         if (accept) begin
            ALU_A <= CMD_A;
            ALU_B <= CMD_B;
            ALU_FUNC <= CMD_FUNC;
         end
      end
   alu_cmd_sequencer_result_byte_serializer #(.W(OUT_DATA_WIDTH)) u_ser (
      .clk   (CLK),
      .rst_n (RST),
      .load  (state_q == WAIT && ALU_OUT_VALID),
      .result(ALU_OUT),
      .ready (TX_READY),
      .valid (ser_valid),
      .data  (ser_data),
      .last  (ser_last)
   );
   assign CMD_READY = rdy_q;
   assign ALU_EN = state_q == ISSUE;
   assign TX_VALID = ser_valid | (state_q == ERRS);
   assign TX_DATA = state_q == ERRS ? ERR_CODE : ser_data;
   assign DONE = done_q;
   assign ERR = err_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed commands against a transaction-level model of the expected byte stream
module tb_alu_cmd_sequencer;
   logic        CLK, RST, CMD_VALID, CMD_READY, ALU_EN, ALU_OUT_VALID;
   logic        TX_VALID, TX_READY, DONE, ERR;
   logic [3:0]  CMD_FUNC, ALU_FUNC;
   logic [15:0] CMD_A, CMD_B, ALU_A, ALU_B, ALU_OUT;
   logic [7:0]  TX_DATA;

   alu_cmd_sequencer dut (
      .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
      .CMD_FUNC(CMD_FUNC), .CMD_A(CMD_A), .CMD_B(CMD_B),
      .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUNC(ALU_FUNC), .ALU_EN(ALU_EN),
      .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
      .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
      .DONE(DONE), .ERR(ERR)
   );

   typedef struct {
      logic [7:0] d;
      bit         last;
      bit         err;
   } exp_t;

   int          n_cmp = 0, n_bad = 0;
   int          cyc = 0, issue_cyc = 0, elat = 0, en_cnt = 0, vcyc = 0;
   int          n_acc = 0, n_done = 0, n_errp = 0, pend = 0;
   int          alu_mode = 0;
   exp_t        q[$];
   logic [7:0]  got[$];
   int          acc[$];
   logic [3:0]  ef, fs;
   logic [15:0] ea, eb, as_, bs_;
   logic        en_s = 0, pv = 0, pr = 0;
   logic [7:0]  pd = 0;

   initial CLK = 0;
   always #5 CLK = ~CLK;

   function automatic logic [15:0] alu_ref(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
      case (f)
         4'd0: return a & b;
         4'd1: return a | b;
         4'd2: return a + b;
         4'd3: return a ^ b;
         default: return a - b;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_got(input string nm, input logic [31:0] exp, input int n);
      chk({nm, "_count"}, got.size(), n);
      for (int i = 0; i < n && i < got.size(); i++) chk(nm, got[i], exp[8*i +: 8]);
   endtask

   // ALU stub: registered flag one cycle after ALU_EN; mode 1 silent, mode 2 holds a stale flag otherwise
   always @(negedge CLK) begin
      en_s = ALU_EN;
      fs = ALU_FUNC;
      as_ = ALU_A;
      bs_ = ALU_B;
   end
   always @(posedge CLK) begin
      #1;
      if (alu_mode == 1) ALU_OUT_VALID = 0;
      else if (en_s) begin
         ALU_OUT_VALID = 1;
         ALU_OUT = alu_ref(fs, as_, bs_);
      end else if (alu_mode == 2) begin
         ALU_OUT_VALID = 1;
         ALU_OUT = 16'hDEAD;
      end else ALU_OUT_VALID = 0;
   end

   always @(negedge CLK) begin
      if (!RST) begin
         q.delete();
         pend = 0;
         pv = 0;
         pr = 0;
         en_cnt = 0;
      end else begin
         cyc++;
         chk("done_pulse", DONE, pend == 1);
         chk("err_pulse", ERR, pend == 2);
         if (pend != 0) begin
            chk("ready_at_end", CMD_READY, 1);
            chk("alu_en_once", en_cnt, 1);
         end
         pend = 0;
         if (DONE) n_done++;
         if (ERR) n_errp++;
         if (pv && !pr) begin
            chk("hold_valid", TX_VALID, 1);
            chk("hold_data", TX_DATA, pd);
         end
         if (ALU_EN) begin
            en_cnt++;
            issue_cyc = cyc;
            chk("alu_a", ALU_A, ea);
            chk("alu_b", ALU_B, eb);
            chk("alu_func", ALU_FUNC, ef);
         end
         if (TX_VALID) begin
            vcyc++;
            if (!pv) chk("tx_latency", cyc - issue_cyc, elat);
            if (q.size() == 0) chk("tx_unexpected", TX_VALID, 0);
            else begin
               chk("tx_data", TX_DATA, q[0].d);
               if (TX_READY) begin
                  got.push_back(TX_DATA);
                  if (q[0].last) pend = q[0].err ? 2 : 1;
                  void'(q.pop_front());
               end
            end
         end
         pv = TX_VALID;
         pr = TX_READY;
         pd = TX_DATA;
         if (CMD_VALID && CMD_READY) begin
            logic [15:0] r;
            n_acc++;
            acc.push_back(cyc);
            en_cnt = 0;
            vcyc = 0;
            ef = CMD_FUNC;
            ea = CMD_A;
            eb = CMD_B;
            r = alu_ref(CMD_FUNC, CMD_A, CMD_B);
            if (alu_mode == 1) begin
               q.push_back('{8'hEE, 1, 1});
               elat = 16;
            end else begin
               q.push_back('{r[7:0], 0, 0});
               q.push_back('{r[15:8], 1, 0});
               elat = 2;
            end
         end
      end
   end

   task automatic cmd(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
      bit ok;
      ok = 0;
      @(posedge CLK);
      #1;
      CMD_VALID = 1;
      CMD_FUNC = f;
      CMD_A = a;
      CMD_B = b;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge CLK);
         ok = CMD_READY;
      end
      if (!ok) chk("cmd_accept", CMD_READY, 1);
      @(posedge CLK);
      #1 CMD_VALID = 0;
   endtask

   task automatic wait_term();
      bit seen;
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge CLK);
         seen = DONE | ERR;
      end
      if (!seen) chk("term_seen", DONE | ERR, 1);
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      RST = 0;
      CMD_VALID = 0;
      CMD_FUNC = 0;
      CMD_A = 0;
      CMD_B = 0;
      TX_READY = 1;
      ALU_OUT = 0;
      ALU_OUT_VALID = 0;
      #3;
      chk("reset_outs", {CMD_READY, ALU_EN, TX_VALID, DONE, ERR, TX_DATA, ALU_A, ALU_B, ALU_FUNC}, 0);
      repeat (2) @(posedge CLK);
      #1 RST = 1;
      chk("ready_in_first_cycle", CMD_READY, 0);
      @(posedge CLK);
      #1 chk("ready_after_reset", CMD_READY, 1);

      got.delete();
      cmd(4'd0, 16'h00F0, 16'h0FF0);
      wait_term();
      chk_got("t1_bytes", 32'h0000_00F0, 2);
      chk("t1_valid_cycles", vcyc, 2);

      got.delete();
      TX_READY = 0;
      cmd(4'd0, 16'h00F0, 16'h0FF0);
      repeat (5) @(posedge CLK);
      #1 TX_READY = 1;
      wait_term();
      chk_got("t2_bytes", 32'h0000_00F0, 2);
      chk("t2_valid_cycles", vcyc, 5);

      got.delete();
      alu_mode = 1;
      cmd(4'd1, 16'h1111, 16'h2222);
      wait_term();
      chk_got("t3_bytes", 32'h0000_00EE, 1);
      chk("t3_valid_cycles", vcyc, 1);
      alu_mode = 0;

      got.delete();
      alu_mode = 2;
      cmd(4'd2, 16'h1000, 16'h0234);
      wait_term();
      chk_got("t4_bytes", 32'h0000_1234, 2);
      alu_mode = 0;

      got.delete();
      cmd(4'd1, 16'h00A0, 16'h0005);
      cmd(4'd3, 16'hFFFF, 16'h0F0F);
      wait_term();
      chk_got("t5_bytes", 32'hF0F0_00A5, 4);
      chk("t5_period", acc[acc.size()-1] - acc[acc.size()-2], 5);

      got.delete();
      cmd(4'd0, 16'hABCD, 16'hFFFF);
      repeat (3) @(posedge CLK);
      #3 RST = 0;
      #1 chk("t6_reset_outs", {CMD_READY, ALU_EN, TX_VALID, DONE, ERR, TX_DATA, ALU_A, ALU_B, ALU_FUNC}, 0);
      chk_got("t6_first_byte", 32'h0000_00CD, 1);
      @(posedge CLK);
      #1 RST = 1;
      @(posedge CLK);
      #1 chk("t6_ready_after_reset", CMD_READY, 1);
      repeat (3) @(posedge CLK);
      got.delete();
      cmd(4'd2, 16'h0100, 16'h0022);
      wait_term();
      chk_got("t6_bytes", 32'h0000_0122, 2);

      chk("accept_count", n_acc, 8);
      chk("done_count", n_done, 6);
      chk("err_count", n_errp, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
